// File: rtl/s27_jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s27_jtag_pkg
// Description : Shared types and constants for the s27 core with its JTAG TAP:
//               TAP state encoding, opcodes, chain lengths, boundary cell
//               positions and the instruction-to-data-register decode.
// Revision    : 1.0 - initial release
// ============================================================================
package s27_jtag_pkg;

    // Sixteen IEEE 1149.1 controller states
    typedef enum logic [3:0] {
        TAP_TLR      = 4'h0,
        TAP_RTI      = 4'h1,
        TAP_SEL_DR   = 4'h2,
        TAP_CAP_DR   = 4'h3,
        TAP_SHIFT_DR = 4'h4,
        TAP_EXIT1_DR = 4'h5,
        TAP_PAUSE_DR = 4'h6,
        TAP_EXIT2_DR = 4'h7,
        TAP_UPD_DR   = 4'h8,
        TAP_SEL_IR   = 4'h9,
        TAP_CAP_IR   = 4'hA,
        TAP_SHIFT_IR = 4'hB,
        TAP_EXIT1_IR = 4'hC,
        TAP_PAUSE_IR = 4'hD,
        TAP_EXIT2_IR = 4'hE,
        TAP_UPD_IR   = 4'hF
    } tap_state_e;

    // Data register addressed by the active instruction
    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_BSR    = 2'd1,
        SEL_SCAN   = 2'd2
    } dr_sel_e;

    localparam int IR_LEN   = 4;
    localparam int BSR_LEN  = 7;
    localparam int SCAN_LEN = 3;

    localparam logic [IR_LEN-1:0] IR_CAPTURE        = 4'b0101;
    localparam logic [IR_LEN-1:0] OP_EXTEST         = 4'b0000;
    localparam logic [IR_LEN-1:0] OP_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [IR_LEN-1:0] OP_SCAN_IN        = 4'b0100;
    localparam logic [IR_LEN-1:0] OP_BYPASS         = 4'b1111;

    // Boundary cell positions; index 0 sits next to tdo, index 6 next to tdi
    localparam int BSR_G17 = 0;
    localparam int BSR_G3  = 1;
    localparam int BSR_G0  = 2;
    localparam int BSR_G1  = 3;
    localparam int BSR_G2  = 4;
    localparam int BSR_VDD = 5;
    localparam int BSR_GND = 6;

    // Unrecognised opcodes fall back to the bypass register
    function automatic dr_sel_e decode_dr(input logic [IR_LEN-1:0] ir);
        dr_sel_e sel;
        case (ir)
            OP_EXTEST,
            OP_SAMPLE_PRELOAD: sel = SEL_BSR;
            OP_SCAN_IN:        sel = SEL_SCAN;
            default:           sel = SEL_BYPASS;
        endcase
        return sel;
    endfunction

endpackage : s27_jtag_pkg
`default_nettype wire

// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_ctrl
// Description : IEEE 1149.1 TAP controller state machine clocked by the system
//               clock, with registered one-hot strobes for the capture, shift
//               and update states of both the DR and IR paths.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl
    import s27_jtag_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic trst_n_i,
    input  logic tms_i,
    output logic tlr_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic update_dr_o,
    output logic capture_ir_o,
    output logic shift_ir_o,
    output logic update_ir_o
);

    tap_state_e state_q;
    tap_state_e state_d;
    logic       tlr_q;
    logic       capture_dr_q;
    logic       shift_dr_q;
    logic       update_dr_q;
    logic       capture_ir_q;
    logic       shift_ir_q;
    logic       update_ir_q;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic m);
        tap_state_e n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:      n = m ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      n = m ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   n = m ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   n = m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: n = m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: n = m ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: n = m ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: n = m ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   n = m ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   n = m ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   n = m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: n = m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: n = m ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: n = m ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: n = m ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   n = m ? TAP_SEL_DR   : TAP_RTI;
            default:      n = TAP_TLR;
        endcase
        return n;
    endfunction

    // Next state; a low trst wins over whatever tms requests
    always_comb begin
        state_d = tap_next(state_q, tms_i);
        if (!trst_n_i) begin
            state_d = TAP_TLR;
        end
    end

    // State register; strobes are decoded from state_d so they match state_q
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= TAP_TLR;
            tlr_q        <= 1'b1;
            capture_dr_q <= 1'b0;
            shift_dr_q   <= 1'b0;
            update_dr_q  <= 1'b0;
            capture_ir_q <= 1'b0;
            shift_ir_q   <= 1'b0;
            update_ir_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tlr_q        <= (state_d == TAP_TLR);
            capture_dr_q <= (state_d == TAP_CAP_DR);
            shift_dr_q   <= (state_d == TAP_SHIFT_DR);
            update_dr_q  <= (state_d == TAP_UPD_DR);
            capture_ir_q <= (state_d == TAP_CAP_IR);
            shift_ir_q   <= (state_d == TAP_SHIFT_IR);
            update_ir_q  <= (state_d == TAP_UPD_IR);
        end
    end

    assign tlr_o        = tlr_q;
    assign capture_dr_o = capture_dr_q;
    assign shift_dr_o   = shift_dr_q;
    assign update_dr_o  = update_dr_q;
    assign capture_ir_o = capture_ir_q;
    assign shift_ir_o   = shift_ir_q;
    assign update_ir_o  = update_ir_q;

endmodule : jtag_tap_ctrl
`default_nettype wire

// File: rtl/s27_jtag.sv
`default_nettype none
// ============================================================================
// Module      : s27_jtag
// Description : ISCAS-89 s27 core wrapped with a JTAG test access port:
//               4-bit IR, 7-cell boundary register, 3-flop internal scan
//               chain over the core state and a bypass bit. The TAP runs on
//               the system clock CK; the tck pin is accepted but not used.
// Revision    : 1.0 - initial release
// ============================================================================
module s27_jtag
    import s27_jtag_pkg::*;
(
    input  logic CK,
    input  logic reset,
    input  logic tck,
    input  logic trst,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    input  logic G0,
    input  logic G1,
    input  logic G2,
    input  logic G3,
    input  logic VDD,
    input  logic GND,
    output logic G17
);

    // tck mirrors CK by board convention; it is not a clock here
    logic tck_unused;
    assign tck_unused = tck;

    // ------------------------------------------------------------------
    // TAP controller
    // ------------------------------------------------------------------
    logic tlr;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;

    jtag_tap_ctrl u_tap (
        .clk_i        (CK),
        .rst_i        (reset),
        .trst_n_i     (trst),
        .tms_i        (tms),
        .tlr_o        (tlr),
        .capture_dr_o (capture_dr),
        .shift_dr_o   (shift_dr),
        .update_dr_o  (update_dr),
        .capture_ir_o (capture_ir),
        .shift_ir_o   (shift_ir),
        .update_ir_o  (update_ir)
    );

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    logic [IR_LEN-1:0] ir_shift_q;
    logic [IR_LEN-1:0] ir_active_q;
    dr_sel_e           dr_sel;
    logic              is_extest;

    assign dr_sel    = decode_dr(ir_active_q);
    assign is_extest = (ir_active_q == OP_EXTEST);

    // IR shift stage shifts LSB-first toward tdo; active IR loads on Update-IR
    always_ff @(posedge CK) begin
        if (reset) begin
            ir_shift_q  <= '0;
            ir_active_q <= OP_BYPASS;
        end else begin
            if (capture_ir) begin
                ir_shift_q <= IR_CAPTURE;
            end else if (shift_ir) begin
                ir_shift_q <= {tdi, ir_shift_q[IR_LEN-1:1]};
            end
            if (!trst || tlr) begin
                ir_active_q <= OP_BYPASS;
            end else if (update_ir) begin
                ir_active_q <= ir_shift_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // s27 core
    // ------------------------------------------------------------------
    logic g5_q;
    logic g6_q;
    logic g7_q;
    logic core_g0;
    logic core_g1;
    logic core_g2;
    logic core_g3;
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
    logic core_g17;
    logic scan_shift;

    logic [BSR_LEN-1:0] bsr_shift_q;
    logic [BSR_LEN-1:0] bsr_store_q;

    // EXTEST drives the core from the boundary stores instead of the pins
    assign core_g0 = is_extest ? bsr_store_q[BSR_G0] : G0;
    assign core_g1 = is_extest ? bsr_store_q[BSR_G1] : G1;
    assign core_g2 = is_extest ? bsr_store_q[BSR_G2] : G2;
    assign core_g3 = is_extest ? bsr_store_q[BSR_G3] : G3;

    // s27 combinational netlist
    always_comb begin
        g14      = ~core_g0;
        g8       = g14 & g6_q;
        g12      = ~(core_g1 | g7_q);
        g15      = g12 | g8;
        g16      = core_g3 | g8;
        g9       = ~(g16 & g15);
        g11      = ~(g5_q | g9);
        g10      = ~(g14 | g11);
        g13      = ~(core_g2 | g12);
        core_g17 = ~g11;
    end

    assign scan_shift = shift_dr && (dr_sel == SEL_SCAN);

    // Core state: scan chain tdi->G5->G6->G7 while shifting SCAN_IN, else functional
    always_ff @(posedge CK) begin
        if (reset) begin
            g5_q <= 1'b0;
            g6_q <= 1'b0;
            g7_q <= 1'b0;
        end else if (scan_shift) begin
            g5_q <= tdi;
            g6_q <= g5_q;
            g7_q <= g6_q;
        end else begin
            g5_q <= g10;
            g6_q <= g11;
            g7_q <= g13;
        end
    end

    // ------------------------------------------------------------------
    // Boundary-scan register
    // ------------------------------------------------------------------
    logic [BSR_LEN-1:0] bsr_capture;

    // Input cells see their pins; the output cell sees the core result
    always_comb begin
        bsr_capture          = '0;
        bsr_capture[BSR_G17] = core_g17;
        bsr_capture[BSR_G3]  = G3;
        bsr_capture[BSR_G0]  = G0;
        bsr_capture[BSR_G1]  = G1;
        bsr_capture[BSR_G2]  = G2;
        bsr_capture[BSR_VDD] = VDD;
        bsr_capture[BSR_GND] = GND;
    end

    // Boundary shift and store flops act only while the BSR is selected
    always_ff @(posedge CK) begin
        if (reset) begin
            bsr_shift_q <= '0;
            bsr_store_q <= '0;
        end else if (dr_sel == SEL_BSR) begin
            if (capture_dr) begin
                bsr_shift_q <= bsr_capture;
            end else if (shift_dr) begin
                bsr_shift_q <= {tdi, bsr_shift_q[BSR_LEN-1:1]};
            end
            if (update_dr) begin
                bsr_store_q <= bsr_shift_q;
            end
        end
    end

    assign G17 = is_extest ? bsr_store_q[BSR_G17] : core_g17;

    // ------------------------------------------------------------------
    // Bypass register
    // ------------------------------------------------------------------
    logic bypass_q;

    // Bypass bit captures 0 and then follows tdi while shifting
    always_ff @(posedge CK) begin
        if (reset) begin
            bypass_q <= 1'b0;
        end else if (dr_sel == SEL_BYPASS) begin
            if (capture_dr) begin
                bypass_q <= 1'b0;
            end else if (shift_dr) begin
                bypass_q <= tdi;
            end
        end
    end

    // ------------------------------------------------------------------
    // tdo: last stage of the selected register, 0 outside shift states
    // ------------------------------------------------------------------
    always_comb begin
        tdo = 1'b0;
        if (shift_ir) begin
            tdo = ir_shift_q[0];
        end else if (shift_dr) begin
            case (dr_sel)
                SEL_BSR:  tdo = bsr_shift_q[0];
                SEL_SCAN: tdo = g7_q;
                default:  tdo = bypass_q;
            endcase
        end
    end

endmodule : s27_jtag
`default_nettype wire

// File: tb/tb_s27_jtag.sv
`default_nettype none
// ============================================================================
// Module      : tb_s27_jtag
// Description : Directed bench for s27_jtag. The stimulus process walks the
//               TAP and queues expected observations; a monitor pops and
//               compares them in the middle of the cycle they belong to.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s27_jtag;

    localparam int K_TDO   = 0;
    localparam int K_G17   = 1;
    localparam int K_IR    = 2;
    localparam int K_STORE = 3;

    logic CK = 1'b0;
    logic tck;
    logic reset, trst, tms, tdi;
    logic G0, G1, G2, G3, VDD, GND;
    logic tdo, G17;

    int cyc_cnt  = 0;
    int checks   = 0;
    int failures = 0;

    int          q_cyc[$];
    int          q_kind[$];
    logic [15:0] q_val[$];
    string       q_name[$];

    s27_jtag dut (
        .CK    (CK),
        .reset (reset),
        .tck   (tck),
        .trst  (trst),
        .tms   (tms),
        .tdi   (tdi),
        .tdo   (tdo),
        .G0    (G0),
        .G1    (G1),
        .G2    (G2),
        .G3    (G3),
        .VDD   (VDD),
        .GND   (GND),
        .G17   (G17)
    );

    always #5 CK = ~CK;
    assign tck = CK;

    always @(posedge CK) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare every queued expectation due in this cycle
    initial begin : mon
        logic [15:0] act;
        forever begin
            @(negedge CK);
            while (q_cyc.size() > 0 && q_cyc[0] <= cyc_cnt) begin
                case (q_kind[0])
                    K_TDO:   act = {15'b0, tdo};
                    K_G17:   act = {15'b0, G17};
                    K_IR:    act = {12'b0, dut.ir_active_q};
                    default: act = {9'b0, dut.bsr_store_q};
                endcase
                checks = checks + 1;
                if (q_cyc[0] != cyc_cnt || act !== q_val[0]) begin
                    failures = failures + 1;
                    $display("FAIL %s: actual=%0h expected=%0h cycle=%0d due=%0d",
                             q_name[0], act, q_val[0], cyc_cnt, q_cyc[0]);
                end
                void'(q_cyc.pop_front());
                void'(q_kind.pop_front());
                void'(q_val.pop_front());
                void'(q_name.pop_front());
            end
        end
    end

    task automatic expect_now(input int kind, input logic [15:0] val, input string name);
        q_cyc.push_back(cyc_cnt);
        q_kind.push_back(kind);
        q_val.push_back(val);
        q_name.push_back(name);
    endtask

    task automatic tick(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        @(posedge CK);
        #1;
    endtask

    // From Run-Test/Idle to Update-IR, checking the captured 0101 on tdo
    task automatic ir_scan(input logic [3:0] op, input string name);
        logic [3:0] cap;
        cap = 4'b0101;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_now(K_TDO, {15'b0, cap[i]}, name);
            tick(i == 3, op[i]);
        end
        tick(1'b1, 1'b0);
    endtask

    // From Run-Test/Idle to Update-DR, shifting din and checking masked tdo bits
    task automatic dr_scan(input int n, input logic [15:0] din, input logic [15:0] exp,
                           input logic [15:0] mask, input string name);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (mask[i]) expect_now(K_TDO, {15'b0, exp[i]}, name);
            tick(i == n - 1, din[i]);
        end
        tick(1'b1, 1'b0);
        expect_now(K_TDO, 16'h0, "upd_dr_tdo");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        reset = 1'b1; trst = 1'b1; tms = 1'b1; tdi = 1'b0;
        G0 = 1'b0; G1 = 1'b0; G2 = 1'b0; G3 = 1'b0; VDD = 1'b0; GND = 1'b0;
        repeat (5) tick(1'b1, 1'b0);
        reset = 1'b0;
        expect_now(K_TDO,   16'h0,  "rst_tdo");
        expect_now(K_IR,    16'hF,  "rst_ir");
        expect_now(K_G17,   16'h1,  "rst_g17");
        expect_now(K_STORE, 16'h00, "rst_store");
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // SAMPLE then preload GND cell only
        G0 = 1'b1; G1 = 1'b1; G2 = 1'b1; G3 = 1'b0; VDD = 1'b0; GND = 1'b1;
        ir_scan(4'b0001, "ir_cap_sample");
        expect_now(K_IR, 16'hF, "ir_latency");
        tick(1'b0, 1'b0);
        expect_now(K_IR, 16'h1, "ir_sample");
        dr_scan(7, 16'h0040, 16'h005D, 16'h007F, "sample_tdo");
        expect_now(K_STORE, 16'h00, "preload_latency");
        tick(1'b0, 1'b0);
        expect_now(K_STORE, 16'h40, "preload_store");
        expect_now(K_G17,   16'h1,  "sample_transparent");

        // EXTEST: G17 pin follows the output-cell store
        ir_scan(4'b0000, "ir_cap_extest");
        expect_now(K_G17, 16'h1, "extest_latency");
        tick(1'b0, 1'b0);
        expect_now(K_G17, 16'h0, "extest_g17");
        dr_scan(7, 16'h0001, 16'h005D, 16'h007F, "extest_tdo");
        expect_now(K_G17, 16'h0, "extest_upd_latency");
        tick(1'b0, 1'b0);
        expect_now(K_G17,   16'h1,  "extest_g17_set");
        expect_now(K_STORE, 16'h01, "extest_store");

        // SCAN_IN: shift 0,1,1 then read them back out
        ir_scan(4'b0100, "ir_cap_scan");
        tick(1'b0, 1'b0);
        dr_scan(6, 16'h0006, 16'h0030, 16'h0038, "scan_tdo");
        tick(1'b0, 1'b0);

        // BYPASS and an unassigned opcode
        ir_scan(4'b1111, "ir_cap_bypass");
        tick(1'b0, 1'b0);
        dr_scan(10, 16'h03FF, 16'h03FE, 16'h03FF, "bypass_tdo");
        tick(1'b0, 1'b0);
        ir_scan(4'b1010, "ir_cap_unk");
        tick(1'b0, 1'b0);
        expect_now(K_IR, 16'hA, "ir_unknown");
        dr_scan(3, 16'h0007, 16'h0006, 16'h0007, "unk_bypass_tdo");
        tick(1'b0, 1'b0);

        // trst mid-shift keeps the stores
        ir_scan(4'b0001, "ir_cap_trst");
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        trst = 1'b0;
        tick(1'b0, 1'b1);
        trst = 1'b1;
        expect_now(K_TDO,   16'h0,  "trst_tdo");
        expect_now(K_IR,    16'hF,  "trst_ir");
        expect_now(K_STORE, 16'h01, "trst_store");
        tick(1'b0, 1'b0);

        // reset mid-shift clears the stores and overrides tms
        ir_scan(4'b0000, "ir_cap_rst");
        tick(1'b0, 1'b0);
        expect_now(K_G17, 16'h1, "extest_after_trst");
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        reset = 1'b1;
        tick(1'b0, 1'b1);
        reset = 1'b0;
        expect_now(K_STORE, 16'h00, "rst_mid_store");
        expect_now(K_IR,    16'hF,  "rst_mid_ir");
        expect_now(K_TDO,   16'h0,  "rst_mid_tdo");
        expect_now(K_G17,   16'h1,  "rst_mid_g17");

        // Drain the scoreboard with a bounded wait
        tick(1'b1, 1'b0);
        for (int w = 0; w < 20 && q_cyc.size() > 0; w++) tick(1'b1, 1'b0);
        if (q_cyc.size() > 0) begin
            failures = failures + q_cyc.size();
            $display("FAIL drain: actual=%0d pending required=0", q_cyc.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_s27_jtag
`default_nettype wire
